booth_product_accumulator: RTL and testbench

//   Downstream consumer of the 4x4 Booth multiplier's 8-bit signed PRODUCT.

---
 rtl/booth_product_accumulator_if.sv | 26 ++
 rtl/booth_product_accumulator.sv | 92 +++++++++
 tb/tb_booth_product_accumulator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_product_accumulator_if.sv
// Handshake bundle between a Booth-product source and the product accumulator:
// product stream in, saturated sum out, plus burst control and status.
interface booth_product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    logic              start;
    logic              prod_valid;
    logic [PROD_W-1:0] prod_data;
    logic              prod_ready;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_data;
    logic              acc_ovf;
    logic              busy;

    modport master (
        output start, prod_valid, prod_data, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_ovf, busy
    );

    modport slave (
        input  start, prod_valid, prod_data, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_ovf, busy
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Sums a burst of NUM_TERMS signed products into a saturating accumulator and
// offers the result on a valid/ready handshake; the accumulate half of a MAC.
module booth_product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int NUM_TERMS = 4
) (
    input logic                       clk,
    input logic                       rst,
    booth_product_accumulator_if.slave bus
);
    localparam int              CNT_W   = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_TERMS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ACC_W:0]     sum;
    logic               pos_clamp, neg_clamp;
    logic [ACC_W-1:0]   sat_sum;

    // One guard bit is enough: the sign bits disagree exactly when the true sum
    // left the ACC_W-bit signed range.
    assign sum       = {acc_q[ACC_W-1], acc_q}
                     + {{(ACC_W+1-PROD_W){bus.prod_data[PROD_W-1]}}, bus.prod_data};
    assign pos_clamp = ~sum[ACC_W] &  sum[ACC_W-1];
    assign neg_clamp =  sum[ACC_W] & ~sum[ACC_W-1];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sat_sum = sum[ACC_W-1:0];
        if (pos_clamp)      sat_sum = ACC_MAX;
        else if (neg_clamp) sat_sum = ACC_MIN;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                end
            end
            ACCUM: begin
                // prod_ready is high throughout ACCUM, so valid alone marks a transfer.
                if (bus.prod_valid) begin
                    acc_d = sat_sum;
                    if (pos_clamp || neg_clamp) ovf_d = 1'b1;
                    if (count_q == LAST) state_d = DONE;
                    else                 count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.acc_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign bus.prod_ready = (state_q == ACCUM);
    assign bus.acc_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.acc_data   = acc_q;
    assign bus.acc_ovf    = ovf_q;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: a 16-bit/4-term instance, a 9-bit instance for saturation and
// a single-term instance, all sharing clock and reset.
module tb_booth_product_accumulator;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    booth_product_accumulator_if #(.PROD_W(8), .ACC_W(16)) a_if ();
    booth_product_accumulator_if #(.PROD_W(8), .ACC_W(9))  b_if ();
    booth_product_accumulator_if #(.PROD_W(8), .ACC_W(16)) c_if ();

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .NUM_TERMS(4)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if));
    booth_product_accumulator #(.PROD_W(8), .ACC_W(9), .NUM_TERMS(4)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if));
    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .NUM_TERMS(1)) dut_c (
        .clk(clk), .rst(rst), .bus(c_if));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Full back-to-back burst on instance A; terms[7:0] is sent first.
    task automatic a_burst(input logic [31:0] terms, input logic [15:0] exp_sum,
                           input logic exp_ovf, input string tag);
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        check({tag, "_busy"},  32'(a_if.busy), 32'd1);
        check({tag, "_clear"}, 32'(a_if.acc_data), 32'h0);
        for (int i = 0; i < 4; i++) begin
            a_if.prod_valid = 1'b1;
            a_if.prod_data  = terms[8*i +: 8];
            step();
        end
        a_if.prod_valid = 1'b0;
        check({tag, "_valid"}, 32'(a_if.acc_valid), 32'd1);
        check({tag, "_data"},  32'(a_if.acc_data), 32'(exp_sum));
        check({tag, "_ovf"},   32'(a_if.acc_ovf), 32'(exp_ovf));
        a_if.acc_ready = 1'b1;
        step();
        a_if.acc_ready = 1'b0;
        check({tag, "_idle"},  32'(a_if.busy), 32'd0);
    endtask

    task automatic b_burst(input logic [31:0] terms, input logic [8:0] exp_sum,
                           input logic exp_ovf, input string tag);
        b_if.start = 1'b1;
        step();
        b_if.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_if.prod_valid = 1'b1;
            b_if.prod_data  = terms[8*i +: 8];
            step();
        end
        b_if.prod_valid = 1'b0;
        check({tag, "_valid"}, 32'(b_if.acc_valid), 32'd1);
        check({tag, "_data"},  32'(b_if.acc_data), 32'(exp_sum));
        check({tag, "_ovf"},   32'(b_if.acc_ovf), 32'(exp_ovf));
        b_if.acc_ready = 1'b1;
        step();
        b_if.acc_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [8:0] b_exp_data [4];
        logic       b_exp_ovf  [4];
        b_exp_data = '{9'h07F, 9'h0FE, 9'h0FF, 9'h0FF};
        b_exp_ovf  = '{1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        a_if.start = 1'b0; a_if.prod_valid = 1'b0; a_if.prod_data = '0; a_if.acc_ready = 1'b0;
        b_if.start = 1'b0; b_if.prod_valid = 1'b0; b_if.prod_data = '0; b_if.acc_ready = 1'b0;
        c_if.start = 1'b0; c_if.prod_valid = 1'b0; c_if.prod_data = '0; c_if.acc_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_prod_ready", 32'(a_if.prod_ready), 32'd0);
        check("rst_acc_valid",  32'(a_if.acc_valid),  32'd0);
        check("rst_busy",       32'(a_if.busy),       32'd0);
        check("rst_acc_data",   32'(a_if.acc_data),   32'h0);
        check("rst_acc_ovf",    32'(a_if.acc_ovf),    32'd0);

        // Mixed-sign burst: 3 - 6 + 10 - 1 = 6
        a_burst(32'hFF0AFA03, 16'h0006, 1'b0, "mixed");
        // Most negative products, then most positive: -512, then 508
        a_burst(32'h80808080, 16'hFE00, 1'b0, "neg");
        a_burst(32'h7F7F7F7F, 16'h01FC, 1'b0, "pos");

        // 9-bit accumulator: 127, 254, clamp 255, clamp 255
        b_if.start = 1'b1;
        step();
        b_if.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_if.prod_valid = 1'b1;
            b_if.prod_data  = 8'h7F;
            step();
            check($sformatf("sat_data_%0d", i), 32'(b_if.acc_data), 32'(b_exp_data[i]));
            check($sformatf("sat_ovf_%0d", i),  32'(b_if.acc_ovf),  32'(b_exp_ovf[i]));
        end
        b_if.prod_valid = 1'b0;
        check("sat_valid", 32'(b_if.acc_valid), 32'd1);
        b_if.acc_ready = 1'b1;
        step();
        b_if.acc_ready = 1'b0;
        // Clamped value is the base for later terms and ovf stays sticky: 255 - 128 = 127
        b_burst(32'h807F7F7F, 9'h07F, 1'b1, "sticky");
        // Next burst clears ovf
        b_burst(32'h00000000, 9'h000, 1'b0, "zeros");
        // -128, -256 (exactly min, no clamp), clamp -256, clamp -256
        b_burst(32'h80808080, 9'h100, 1'b1, "negsat");

        // Backpressure on the product side
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        a_if.prod_valid = 1'b1; a_if.prod_data = 8'h10; step();
        a_if.prod_valid = 1'b0; a_if.prod_data = 8'h7F; step();
        a_if.prod_valid = 1'b1; a_if.prod_data = 8'h20; step();
        a_if.prod_valid = 1'b0; a_if.prod_data = 8'h7F; step();
        a_if.prod_valid = 1'b1; a_if.prod_data = 8'h30; step();
        a_if.prod_valid = 1'b0; a_if.prod_data = 8'h7F; step();
        check("bp_three_terms_valid", 32'(a_if.acc_valid), 32'd0);
        check("bp_three_terms_data",  32'(a_if.acc_data),  32'h0060);
        a_if.prod_valid = 1'b1; a_if.prod_data = 8'h40; step();
        // Products offered while DONE must be ignored
        a_if.prod_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_valid_%0d", i), 32'(a_if.acc_valid),  32'd1);
            check($sformatf("bp_hold_data_%0d", i),  32'(a_if.acc_data),   32'h00A0);
            check($sformatf("bp_hold_ready_%0d", i), 32'(a_if.prod_ready), 32'd0);
            step();
        end
        a_if.prod_valid = 1'b0;
        a_if.acc_ready  = 1'b1;
        step();
        a_if.acc_ready  = 1'b0;
        check("bp_release_valid", 32'(a_if.acc_valid), 32'd0);
        check("bp_release_busy",  32'(a_if.busy),      32'd0);

        // Reset mid-burst discards the partial sum
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        a_if.prod_valid = 1'b1; a_if.prod_data = 8'h7F; step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_if.prod_valid = 1'b0;
        check("midrst_busy",       32'(a_if.busy),       32'd0);
        check("midrst_prod_ready", 32'(a_if.prod_ready), 32'd0);
        check("midrst_acc_valid",  32'(a_if.acc_valid),  32'd0);
        check("midrst_acc_data",   32'(a_if.acc_data),   32'h0);
        check("midrst_acc_ovf",    32'(a_if.acc_ovf),    32'd0);
        a_burst(32'h01010101, 16'h0004, 1'b0, "after_rst");

        // start pulses inside ACCUM and DONE are ignored
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        a_if.prod_valid = 1'b1; a_if.prod_data = 8'h05; step();
        a_if.start = 1'b1;      a_if.prod_data = 8'h06; step();
        a_if.start = 1'b0;      a_if.prod_data = 8'h07; step();
        check("start_accum_count", 32'(a_if.acc_valid), 32'd0);
        a_if.prod_data = 8'h08; step();
        a_if.prod_valid = 1'b0;
        check("start_accum_data", 32'(a_if.acc_data), 32'h001A);
        a_if.start = 1'b1;
        step();
        step();
        a_if.start = 1'b0;
        check("start_done_valid", 32'(a_if.acc_valid), 32'd1);
        check("start_done_data",  32'(a_if.acc_data),  32'h001A);
        a_if.acc_ready = 1'b1;
        step();
        // IDLE: products and a held acc_ready have no effect
        a_if.prod_valid = 1'b1; a_if.prod_data = 8'h7F;
        step();
        step();
        check("idle_prod_ready", 32'(a_if.prod_ready), 32'd0);
        check("idle_busy",       32'(a_if.busy),       32'd0);
        check("idle_acc_valid",  32'(a_if.acc_valid),  32'd0);
        check("idle_acc_data",   32'(a_if.acc_data),   32'h001A);
        a_if.prod_valid = 1'b0;
        a_if.acc_ready  = 1'b0;

        // Single-term burst goes straight to DONE
        c_if.start = 1'b1;
        step();
        c_if.start = 1'b0;
        c_if.prod_valid = 1'b1; c_if.prod_data = 8'hFE;
        step();
        c_if.prod_valid = 1'b0;
        check("one_term_valid", 32'(c_if.acc_valid), 32'd1);
        check("one_term_data",  32'(c_if.acc_data),  32'h0000FFFE);
        c_if.acc_ready = 1'b1;
        step();
        c_if.acc_ready = 1'b0;
        check("one_term_idle", 32'(c_if.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
